// File: rtl/mul12_seq_ctrl_if.sv
// Operand/result handshake bundle between a requesting datapath and mul12_seq_ctrl.
// The master drives operands and result acceptance; the slave is the controller.
interface mul12_seq_ctrl_if #(
    parameter int HALF_W = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*HALF_W-1:0]   in_a;
    logic [2*HALF_W-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*HALF_W-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/mul12_seq_ctrl.sv
// 12x12 unsigned multiply sequenced over one shared 6x6 multiplier in four half-word steps.
// Define MUL_OUT_REG_EN to register mul_p before accumulation (adds one cycle of latency).
module mul12_seq_ctrl #(
    parameter int HALF_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    mul12_seq_ctrl_if.slave      bus,
    output logic [HALF_W-1:0]    mul_a,
    output logic [HALF_W-1:0]    mul_b,
    input  logic [2*HALF_W-1:0]  mul_p,
    output logic                 busy
);
    localparam int OP_W  = 2 * HALF_W;
    localparam int RES_W = 4 * HALF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef MUL_OUT_REG_EN
    localparam logic [2:0] LAST_STEP = 3'd4;
`else
    localparam logic [2:0] LAST_STEP = 3'd3;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_step;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [RES_W-1:0]    r_acc;

    logic                w_accept;
    logic [OP_W-1:0]     w_pp;
    logic [1:0]          w_pp_step;
    logic                w_pp_en;
    logic [RES_W-1:0]    w_pp_shifted [4];

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

`ifdef MUL_OUT_REG_EN
    logic [OP_W-1:0] r_mul_p_pipe;

    // Free-running capture; acc is cleared on accept, so stale contents never leak into a job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_p_pipe <= '0;
        end else begin
            r_mul_p_pipe <= mul_p;
        end
    end

    assign w_pp      = r_mul_p_pipe;
    assign w_pp_step = 2'(r_step - 3'd1);
    assign w_pp_en   = (r_step != 3'd0);
`else
    assign w_pp      = mul_p;
    assign w_pp_step = r_step[1:0];
    assign w_pp_en   = 1'b1;
`endif

    // Step weights: aL*bL -> 0, cross terms -> HALF_W, aH*bH -> 2*HALF_W.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp_shift
            localparam int SH = ((gi & 1) + (gi >> 1)) * HALF_W;
            assign w_pp_shifted[gi] = {{(RES_W-OP_W){1'b0}}, w_pp} << SH;
        end
    endgenerate

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= bus.in_a;
                        r_b    <= bus.in_b;
                        r_acc  <= '0;
                        r_step <= '0;
                    end
                end
                S_MUL: begin
                    r_step <= r_step + 3'd1;
                    if (w_pp_en) begin
                        r_acc <= r_acc + w_pp_shifted[w_pp_step];
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_MUL;
            S_MUL:   if (r_step == LAST_STEP) w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs; the multiplier operands stay at zero whenever no step is being issued.
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        bus.out_p     = (r_state == S_DONE) ? r_acc : '0;
        busy          = (r_state != S_IDLE);
        mul_a         = '0;
        mul_b         = '0;
        if ((r_state == S_MUL) && !r_step[2]) begin
            mul_a = r_step[1] ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
            mul_b = r_step[0] ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];
        end
    end
endmodule

// File: tb/tb_mul12_seq_ctrl.sv
// Self-checking bench for mul12_seq_ctrl: directed cases plus randomized jobs with random backpressure,
// all checked against a job-queue reference model of the handshake, step sequence and product.
module tb_mul12_seq_ctrl;
    localparam int HALF_W = 6;
`ifdef MUL_OUT_REG_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  mul_a;
    logic [5:0]  mul_b;
    logic [11:0] mul_p;
    logic        busy;

    always #5 clk = ~clk;

    mul12_seq_ctrl_if #(.HALF_W(HALF_W)) bus ();

    // Behavioural stand-in for the shared 6x6 array.
    assign mul_p = mul_a * mul_b;

    mul12_seq_ctrl #(.HALF_W(HALF_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [11:0] qa [$];
    logic [11:0] qb [$];
    int          qt [$];
    logic [23:0] last_p = '0;
    int          last_acc = -1;
    bit          check_spacing = 1'b0;
    bit          rand_bp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: one outstanding job at a time, product = a*b, result after LAT cycles.
    always @(negedge clk) begin
        bit          have;
        int          age;
        logic [11:0] a0;
        logic [11:0] b0;
        logic [23:0] exp_p;
        cyc++;
        if (rst) begin
            qa.delete();
            qb.delete();
            qt.delete();
        end else begin
            have = (qa.size() != 0);
            age  = have ? (cyc - qt[0]) : 0;
            a0   = have ? qa[0] : 12'd0;
            b0   = have ? qb[0] : 12'd0;
            chk("busy", busy, have);
            chk("in_ready", bus.in_ready, !have);
            chk("out_valid", bus.out_valid, have && (age >= LAT));
            if (have && age >= 1 && age <= 4) begin
                chk("mul_a", mul_a, (age <= 2) ? a0[5:0] : a0[11:6]);
                chk("mul_b", mul_b, (age == 1 || age == 3) ? b0[5:0] : b0[11:6]);
            end else begin
                chk("mul_a_quiet", mul_a, 0);
                chk("mul_b_quiet", mul_b, 0);
            end
            if (bus.out_valid && have) begin
                exp_p = a0 * b0;
                chk("out_p", bus.out_p, exp_p);
                if (bus.out_ready) begin
                    last_p = bus.out_p;
                    $display("job %03h * %03h -> %06h (accepted cycle %0d, delivered cycle %0d)",
                             a0, b0, bus.out_p, qt[0], cyc);
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                    void'(qt.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (check_spacing && last_acc >= 0) chk("accept_spacing", cyc - last_acc, LAT + 1);
                last_acc = cyc;
                qa.push_back(bus.in_a);
                qb.push_back(bus.in_b);
                qt.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [11:0] a, input logic [11:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("send_timeout", n, 0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 12'($urandom);
        bus.in_b     = 12'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (qa.size() != 0 || busy) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                chk("idle_timeout", n, 0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] held_p;
        int          n;
        bit          done;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_p", bus.out_p, 0);
        chk("rst_mul_a", mul_a, 0);

        send(12'h123, 12'h456); wait_idle();
        chk("t1_p", last_p, 24'h04EDC2);
        send(12'hFFF, 12'hFFF); wait_idle();
        chk("t2_p", last_p, 24'hFFE001);
        send(12'h000, 12'hABC); wait_idle();
        chk("t3a_p", last_p, 24'h000000);
        send(12'h040, 12'h040); wait_idle();
        chk("t3b_p", last_p, 24'h001000);

        // Backpressure: hold the result for three cycles, release on the fourth.
        bus.out_ready = 1'b0;
        send(12'h7A3, 12'h19C);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_seen", bus.out_valid, 1);
        held_p = bus.out_p;
        for (int i = 0; i < 3; i++) begin
            chk("bp_p_stable", bus.out_p, held_p);
            chk("bp_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", bus.out_valid, 0);
        chk("bp_in_ready_after", bus.in_ready, 1);
        chk("bp_p", last_p, 24'h7A3 * 24'h19C);

        // Abort mid-job at step 2.
        send(12'h5A5, 12'h3C3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_step2_mul_a", mul_a, 6'h16);
        chk("abort_step2_mul_b", mul_b, 6'h03);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        send(12'h002, 12'h003); wait_idle();
        chk("abort_next_p", last_p, 24'h000006);

        // Back-to-back queued requests.
        last_acc      = -1;
        check_spacing = 1'b1;
        send(12'h321, 12'h654);
        send(12'hABC, 12'hDEF);
        send(12'h001, 12'hFFF);
        send(12'h800, 12'h800);
        wait_idle();
        check_spacing = 1'b0;
        chk("stream_last_p", last_p, 24'h400000);

        // Random operands with random result backpressure.
        done    = 1'b0;
        rand_bp = 1'b1;
        fork
            begin
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    send(12'($urandom), 12'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
